// File: rtl/window_3x3_gen.sv
// Streaming 3x3 window generator with two internal line buffers; FRAME_CNT_EN adds frame_count.
// Windows are registered one cycle after the accepting edge; enable low or cfg_err stalls all state.
module window_3x3_gen #(
    parameter int DATA_W    = 8,
    parameter int MAX_WIDTH = 1024,
    parameter int ADDR_W    = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                enable,
    input  logic [15:0]         width,
    input  logic [15:0]         high,
    input  logic [DATA_W-1:0]   pix_in,
    input  logic                pix_valid_in,
    output logic [9*DATA_W-1:0] win_out,
    output logic                win_valid,
    output logic                frame_done,
`ifdef FRAME_CNT_EN
    output logic [31:0]         frame_count,
`endif
    output logic                cfg_err
);

    localparam logic [15:0] MAX_W16 = 16'(MAX_WIDTH);

    logic [DATA_W-1:0]   lb1 [MAX_WIDTH];
    logic [DATA_W-1:0]   lb2 [MAX_WIDTH];
    logic [15:0]         col, row, w_q, h_q, w_eff, h_eff;
    logic                start;
    logic [3*DATA_W-1:0] col_a, col_b, col_new;
    logic [9*DATA_W-1:0] win_nxt;
    logic [DATA_W-1:0]   above1, above2;
    logic [ADDR_W-1:0]   idx;
    logic                accept, geom_bad, take, col_last, row_last;

    assign idx      = col[ADDR_W-1:0];
    assign above1   = lb1[idx];
    assign above2   = lb2[idx];
    assign w_eff    = start ? width : w_q;
    assign h_eff    = start ? high  : h_q;
    assign accept   = pix_valid_in & enable & ~cfg_err;
    assign geom_bad = start & ((width < 16'd3) | (width > MAX_W16) | (high < 16'd3));
    assign take     = accept & ~geom_bad;
    assign col_last = (col == w_eff - 16'd1);
    assign row_last = (row == h_eff - 16'd1);
    // Column packing: r0 (oldest line) in the low bits.
    assign col_new  = {pix_in, above1, above2};

    always_comb begin
        win_nxt = '0;
        for (int r = 0; r < 3; r++) begin
            win_nxt[DATA_W*(3*r+0) +: DATA_W] = col_a[DATA_W*r +: DATA_W];
            win_nxt[DATA_W*(3*r+1) +: DATA_W] = col_b[DATA_W*r +: DATA_W];
            win_nxt[DATA_W*(3*r+2) +: DATA_W] = col_new[DATA_W*r +: DATA_W];
        end
    end

    // Line buffers are deliberately not reset; row gating hides stale contents.
    always_ff @(posedge clk) begin
        if (take) begin
            lb2[idx] <= above1;
            lb1[idx] <= pix_in;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_out    <= '0;
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            cfg_err    <= 1'b0;
            col        <= '0;
            row        <= '0;
            w_q        <= '0;
            h_q        <= '0;
            start      <= 1'b1;
            col_a      <= '0;
            col_b      <= '0;
`ifdef FRAME_CNT_EN
            frame_count <= '0;
`endif
        end else begin
            win_valid  <= 1'b0;
            frame_done <= 1'b0;
            if (!enable && cfg_err) begin
                cfg_err <= 1'b0;
                start   <= 1'b1;
            end
            if (accept && geom_bad)
                cfg_err <= 1'b1;
            if (take) begin
                if (start) begin
                    w_q   <= width;
                    h_q   <= high;
                    start <= 1'b0;
                end
                col_a <= col_b;
                col_b <= col_new;
                if (row >= 16'd2 && col >= 16'd2) begin
                    win_out   <= win_nxt;
                    win_valid <= 1'b1;
                end
                if (col_last) begin
                    col <= '0;
                    if (row_last) begin
                        row        <= '0;
                        start      <= 1'b1;
                        frame_done <= 1'b1;
`ifdef FRAME_CNT_EN
                        frame_count <= frame_count + 32'd1;
`endif
                    end else begin
                        row <= row + 16'd1;
                    end
                end else begin
                    col <= col + 16'd1;
                end
            end
        end
    end

endmodule
